water_collider: RTL and testbench

- Consumes the water-drop position from the water mover and tests it against the plane's bounding box once per frame.
- On first overlap it emits a one-cycle hit pulse and bumps a saturating collection score.
- It then stays disarmed until the drop wraps back to the top, so each drop pass scores at most once.
- Sits between the water mover and the score/HUD renderer.

---
 rtl/water_collider.sv | 107 ++++++++++
 tb/tb_water_collider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/water_collider.sv
// Drop-vs-plane bounding-box collider: one hit per drop pass, saturating score.
// Re-arms when the drop wraps back to the top (seen as a y decrease).
module water_collider #(
    parameter int PLANE_W = 64,
    parameter int PLANE_H = 64,
    parameter int WATER_W = 32,
    parameter int WATER_H = 32,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               frame,
    input  logic [10:0]        plane_x,
    input  logic [10:0]        plane_y,
    input  logic [10:0]        water_x,
    input  logic [10:0]        water_y,
    output logic               hit,
    output logic               armed,
    output logic [SCORE_W-1:0] score,
    output logic               score_max
);

    typedef enum logic {
        ARMED,
        SPENT
    } state_t;

    state_t             state_q, state_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               max_q, max_d;
    logic [10:0]        last_y_q, last_y_d;

    logic [11:0] px, py, wx, wy;
    logic        overlap;
    logic        wrap;

    // 12-bit operands so that position + size can never wrap around.
    assign px = {1'b0, plane_x};
    assign py = {1'b0, plane_y};
    assign wx = {1'b0, water_x};
    assign wy = {1'b0, water_y};

    assign overlap = (wx < px + 12'(PLANE_W)) &
                     (px < wx + 12'(WATER_W)) &
                     (wy < py + 12'(PLANE_H)) &
                     (py < wy + 12'(WATER_H));

    assign wrap = frame & (water_y < last_y_q);

    always_comb begin
        state_d  = state_q;
        hit_d    = 1'b0;
        score_d  = score_q;
        last_y_d = last_y_q;
        if (clear) begin
            state_d  = ARMED;
            score_d  = '0;
            last_y_d = water_y;
        end else begin
            if (frame) begin
                last_y_d = water_y;
            end
            case (state_q)
                ARMED: begin
                    if (frame && overlap) begin
                        hit_d   = 1'b1;
                        state_d = SPENT;
                        if (!(&score_q)) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                end
                SPENT: begin
                    if (wrap) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
        max_d = &score_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARMED;
            hit_q    <= 1'b0;
            score_q  <= '0;
            max_q    <= 1'b0;
            last_y_q <= '0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            max_q    <= max_d;
            last_y_q <= last_y_d;
        end
    end

    assign hit       = hit_q;
    assign armed     = (state_q == ARMED);
    assign score     = score_q;
    assign score_max = max_q;

endmodule

// File: tb/tb_water_collider.sv
// Directed bench for water_collider: default 8-bit score and a 2-bit
// instance sharing the same stimulus to reach saturation quickly.
module tb_water_collider;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        frame;
    logic [10:0] plane_x, plane_y, water_x, water_y;

    logic       hit8, armed8, smax8;
    logic [7:0] score8;
    logic       hit2, armed2, smax2;
    logic [1:0] score2;

    int checks = 0;
    int errors = 0;

    water_collider u8 (
        .clk(clk), .rst(rst), .clear(clear), .frame(frame),
        .plane_x(plane_x), .plane_y(plane_y),
        .water_x(water_x), .water_y(water_y),
        .hit(hit8), .armed(armed8), .score(score8), .score_max(smax8)
    );

    water_collider #(.SCORE_W(2)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .frame(frame),
        .plane_x(plane_x), .plane_y(plane_y),
        .water_x(water_x), .water_y(water_y),
        .hit(hit2), .armed(armed2), .score(score2), .score_max(smax2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        water_x = x;
        water_y = y;
        frame   = 1'b1;
        @(negedge clk);
        frame   = 1'b0;
    endtask

    task automatic do_clear(input logic with_frame);
        @(negedge clk);
        clear = 1'b1;
        frame = with_frame;
        @(negedge clk);
        clear = 1'b0;
        frame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; frame = 1'b0;
        plane_x = 11'd300; plane_y = 11'd600;
        water_x = 11'd0;   water_y = 11'd0;
        #3;
        check("rst_armed", armed8, 1);
        check("rst_hit", hit8, 0);
        check("rst_score", score8, 0);
        check("rst_smax", smax8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Bottom edge of drop exactly at plane top: touch only.
        do_frame(11'd310, 11'd568);
        check("touch_hit", hit8, 0);
        check("touch_score", score8, 0);
        check("touch_armed", armed8, 1);

        do_frame(11'd310, 11'd569);
        check("hit1_hit", hit8, 1);
        check("hit1_score", score8, 1);
        check("hit1_armed", armed8, 0);
        @(negedge clk);
        check("hit1_fall", hit8, 0);

        for (int i = 0; i < 10; i++) begin
            do_frame(11'd310, 11'(570 + i));
            check("spent_hit", hit8, 0);
        end
        check("spent_score", score8, 1);
        check("spent_armed", armed8, 0);

        do_frame(11'd310, 11'd768);
        check("y768_armed", armed8, 0);
        plane_x = 11'd300; plane_y = 11'd100;
        do_frame(11'd310, 11'd128);
        check("wrap_armed", armed8, 1);
        check("wrap_hit", hit8, 0);
        check("wrap_score", score8, 1);

        do_frame(11'd310, 11'd129);
        check("hit2_hit", hit8, 1);
        check("hit2_score8", score8, 2);
        check("hit2_score2", score2, 2);
        check("hit2_armed", armed8, 0);

        do_clear(1'b0);
        check("clr_score2", score2, 0);
        check("clr_smax2", smax2, 0);
        check("clr_armed2", armed2, 1);

        for (int k = 1; k <= 4; k++) begin
            do_frame(11'd310, 11'd121);
            check("sat_hit2", hit2, 1);
            check("sat_score2", score2, (k >= 3) ? 3 : k);
            check("sat_smax2", smax2, (k >= 3) ? 1 : 0);
            check("sat_score8", score8, k);
            check("sat_smax8", smax8, 0);
            do_frame(11'd310, 11'd120);
            check("sat_wrap_armed", armed2, 1);
            check("sat_wrap_hit", hit2, 0);
        end

        // Frame coincident with clear, drop overlapping: no hit.
        water_x = 11'd310; water_y = 11'd121;
        do_clear(1'b1);
        check("clrf_hit", hit2, 0);
        check("clrf_score2", score2, 0);
        check("clrf_smax2", smax2, 0);
        check("clrf_armed2", armed2, 1);
        check("clrf_score8", score8, 0);

        do_frame(11'd310, 11'd121);
        check("pre_rst_armed", armed8, 0);
        check("pre_rst_score", score8, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_armed", armed8, 1);
        check("arst_hit", hit8, 0);
        check("arst_score", score8, 0);
        check("arst_smax2", smax2, 0);
        @(negedge clk);
        rst = 1'b1;

        do_frame(11'd310, 11'd121);
        check("post_rst_hit", hit8, 1);
        check("post_rst_score", score8, 1);
        check("post_rst_armed", armed8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
